// File: rtl/tri_bisect_engine.sv
// tri_bisect_engine: depth-first longest-edge bisection of one projected
// triangle into leaf triangles, streamed out over a valid/ready handshake.
// Triangles are packed {P,Q,R}, each vertex {x,y,z}; P and x sit at the MSB.

// Squared 2D (x,y) length between two vertices, full precision.
module tbe_edge_sq #(
    parameter int CW = 16,
    parameter int TW = 2*CW+3
) (
    input  logic [2:0][CW-1:0] va,
    input  logic [2:0][CW-1:0] vb,
    output logic [TW-1:0]      len_sq
);
    logic [CW:0]     dx_n, dy_n;
    logic [2*CW+1:0] dx, dy, sx, sy;

    // Differences in CW+1 bits cannot overflow; squares fit in 2*CW+2 bits,
    // so a modular unsigned multiply of the sign-extended values is exact.
    always_comb begin
        dx_n   = {va[2][CW-1], va[2]} - {vb[2][CW-1], vb[2]};
        dy_n   = {va[1][CW-1], va[1]} - {vb[1][CW-1], vb[1]};
        dx     = {{(CW+1){dx_n[CW]}}, dx_n};
        dy     = {{(CW+1){dy_n[CW]}}, dy_n};
        sx     = dx * dx;
        sy     = dy * dy;
        len_sq = TW'(sx) + TW'(sy);
    end
endmodule

// One-axis midpoint, floor((a+b)/2) with no intermediate overflow.
module tbe_mid #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    output logic [CW-1:0] m
);
    logic [CW:0] sum;

    assign sum = {a[CW-1], a} + {b[CW-1], b};
    // Dropping the LSB of the sign-extended sum is an arithmetic shift.
    assign m   = CW'(sum >> 1);
endmodule

module tri_bisect_engine #(
    parameter int CW        = 16,
    parameter int MAX_LEVEL = 4,
    parameter int TW        = 2*CW+3
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [9*CW-1:0]                in_tri,
    input  logic [TW-1:0]                  thresh_sq,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [9*CW-1:0]                out_tri,
    output logic [$clog2(MAX_LEVEL+1)-1:0] out_level,
    output logic                           out_last,
    input  logic                           abort,
    output logic                           busy
);
    localparam int LW = $clog2(MAX_LEVEL+1);
    localparam int IW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

    typedef logic [2:0][CW-1:0] vtx_t;
    typedef vtx_t [2:0]         tri_t;
    typedef enum logic [1:0] {IDLE, EVAL, SPLIT, EMIT} state_t;

    state_t          state, state_nx;
    tri_t            cur;
    logic [LW-1:0]   level;
    logic [TW-1:0]   thr;
    logic [LW-1:0]   sp;

    // One pending T2 per level at most, so MAX_LEVEL entries never overflow.
    tri_t            stk_tri [MAX_LEVEL];
    logic [LW-1:0]   stk_lvl [MAX_LEVEL];
    logic [IW-1:0]   push_idx, pop_idx;

    logic [2:0][TW-1:0] elen;
    logic [TW-1:0]      longest;
    vtx_t               va, vb, vc, vm;
    logic               is_leaf, stk_empty;

    // Edge k joins vertex (2-k) to vertex ((4-k)%3): PQ, QR, RP.
    for (genvar k = 0; k < 3; k++) begin : g_edge
        tbe_edge_sq #(.CW(CW), .TW(TW)) u_edge (
            .va     (cur[2-k]),
            .vb     (cur[(4-k)%3]),
            .len_sq (elen[k])
        );
    end

    // Midpoint of the chosen edge, per axis x/y/z.
    for (genvar j = 0; j < 3; j++) begin : g_mid
        tbe_mid #(.CW(CW)) u_mid (
            .a (va[j]),
            .b (vb[j]),
            .m (vm[j])
        );
    end

    // Pick the longest edge (ties to the lower index) and name its endpoints
    // A,B plus the opposite vertex C; cur is unchanged from EVAL to SPLIT, so
    // SPLIT reuses this selection without registering it.
    always_comb begin
        va      = cur[2];
        vb      = cur[1];
        vc      = cur[0];
        longest = elen[0];
        if (elen[0] >= elen[1] && elen[0] >= elen[2]) begin
            va = cur[2]; vb = cur[1]; vc = cur[0]; longest = elen[0];
        end else if (elen[1] >= elen[2]) begin
            va = cur[1]; vb = cur[0]; vc = cur[2]; longest = elen[1];
        end else begin
            va = cur[0]; vb = cur[2]; vc = cur[1]; longest = elen[2];
        end
    end

    assign is_leaf   = (longest <= thr) || (level == LW'(MAX_LEVEL));
    assign stk_empty = (sp == '0);
    assign push_idx  = IW'(sp);
    assign pop_idx   = IW'(sp - LW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs; abort overrides every transition.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        out_tri   = cur;
        out_level = level;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = EVAL;
            end
            EVAL:  state_nx = is_leaf ? EMIT : SPLIT;
            SPLIT: state_nx = EVAL;
            EMIT: begin
                out_valid = 1'b1;
                out_last  = stk_empty;
                if (out_ready) state_nx = stk_empty ? IDLE : EVAL;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Working triangle, level, threshold and stack pointer.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cur   <= '0;
            level <= '0;
            thr   <= '0;
            sp    <= '0;
        end else if (abort) begin
            sp <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cur   <= in_tri;
                    level <= '0;
                    thr   <= thresh_sq;
                end
                SPLIT: begin
                    cur   <= {va, vm, vc};
                    level <= level + LW'(1);
                    sp    <= sp + LW'(1);
                end
                EMIT: if (out_ready && !stk_empty) begin
                    cur   <= stk_tri[pop_idx];
                    level <= stk_lvl[pop_idx];
                    sp    <= sp - LW'(1);
                end
                default: ;
            endcase
        end
    end

    // Stack storage: the deferred T2 half of each split.
    always_ff @(posedge clk) begin
        if (n_rst && !abort && state == SPLIT) begin
            stk_tri[push_idx] <= {vm, vb, vc};
            stk_lvl[push_idx] <= level + LW'(1);
        end
    end
endmodule

// File: tb/tb_tri_bisect_engine.sv
// Self-checking bench for tri_bisect_engine: directed test-plan cases,
// abort/reset flushes and randomized triangles against a depth-first model.
module tb_tri_bisect_engine;
    localparam int CW = 16;
    localparam int ML = 4;
    localparam int TW = 2*CW+3;
    localparam int LW = $clog2(ML+1);

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              abort = 1'b0;
    logic [9*CW-1:0]   in_tri = '0;
    logic [TW-1:0]     thresh_sq = '0;
    logic              in_ready, out_valid, out_last, busy;
    logic [9*CW-1:0]   out_tri;
    logic [LW-1:0]     out_level;

    int total = 0;
    int bad   = 0;

    tri_bisect_engine #(.CW(CW), .MAX_LEVEL(ML), .TW(TW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tri    (in_tri),
        .thresh_sq (thresh_sq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tri   (out_tri),
        .out_level (out_level),
        .out_last  (out_last),
        .abort     (abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [9*CW-1:0] t; int lvl; } node_t;
    typedef struct { logic [9*CW-1:0] t; int lvl; int lat; logic last; } leaf_t;
    leaf_t exp_q[$];

    task automatic chk(input string tag, input logic [9*CW-1:0] obs, input logic [9*CW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9*CW-1:0] tri9(input int px, py, pz, qx, qy, qz, rx, ry, rz);
        return {CW'(px), CW'(py), CW'(pz), CW'(qx), CW'(qy), CW'(qz), CW'(rx), CW'(ry), CW'(rz)};
    endfunction

    function automatic int crd(input logic [9*CW-1:0] t, input int k);
        logic [CW-1:0] w;
        w = t[(8-k)*CW +: CW];
        return int'($signed(w));
    endfunction

    // Reference: explicit depth-first work list, T1 explored before T2.
    task automatic build_exp(input logic [9*CW-1:0] t, input logic [TW-1:0] thr);
        node_t  stk[$];
        node_t  n, n1, n2;
        leaf_t  lf;
        int     v[3][3];
        int     m[3];
        longint e[3];
        longint dx, dy;
        int     k, a, b, c, start;
        bit     new_chain;
        exp_q.delete();
        new_chain = 1;
        start = 0;
        n.t = t; n.lvl = 0;
        stk.push_back(n);
        while (stk.size() > 0) begin
            n = stk.pop_back();
            if (new_chain) begin start = n.lvl; new_chain = 0; end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) v[i][j] = crd(n.t, 3*i+j);
            for (int i = 0; i < 3; i++) begin
                dx = longint'(v[i][0] - v[(i+1)%3][0]);
                dy = longint'(v[i][1] - v[(i+1)%3][1]);
                e[i] = dx*dx + dy*dy;
            end
            k = 0;
            if (e[1] > e[k]) k = 1;
            if (e[2] > e[k]) k = 2;
            if (e[k] <= longint'(thr) || n.lvl == ML) begin
                lf.t = n.t; lf.lvl = n.lvl; lf.lat = 2 + 2*(n.lvl - start); lf.last = 1'b0;
                exp_q.push_back(lf);
                new_chain = 1;
            end else begin
                a = k; b = (k+1)%3; c = (k+2)%3;
                for (int ax = 0; ax < 3; ax++) m[ax] = (v[a][ax] + v[b][ax]) >>> 1;
                n2.t = tri9(m[0], m[1], m[2], v[b][0], v[b][1], v[b][2], v[c][0], v[c][1], v[c][2]);
                n1.t = tri9(v[a][0], v[a][1], v[a][2], m[0], m[1], m[2], v[c][0], v[c][1], v[c][2]);
                n1.lvl = n.lvl + 1;
                n2.lvl = n.lvl + 1;
                stk.push_back(n2);
                stk.push_back(n1);
                total++;
                assert (stk.size() - 1 <= ML) else begin
                    bad++;
                    $error("FAIL stack_depth observed=%0d expected<=%0d", stk.size() - 1, ML);
                end
            end
        end
        exp_q[exp_q.size()-1].last = 1'b1;
    endtask

    // Feed one triangle and check every leaf; kill_at>0 flushes (abort or
    // reset) while that leaf is presented.
    task automatic run_tri(input logic [9*CW-1:0] t, input logic [TW-1:0] thr,
                           input bit rand_stall, input bit long_stall,
                           input int kill_at, input bit kill_rst,
                           output logic [9*CW-1:0] first, output int nleaves);
        leaf_t e;
        int    idx, cyc, stall_n;
        build_exp(t, thr);
        first = '0;
        nleaves = 0;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1'b1);
        in_tri = t; thresh_sq = thr; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_tri = ~t;
        thresh_sq = TW'({$urandom, $urandom});
        chk("busy_after_accept", busy, 1'b1);
        chk("in_ready_busy", in_ready, 1'b0);
        idx = 0; cyc = 1;
        while (idx < exp_q.size()) begin
            e = exp_q[idx];
            while (!out_valid && cyc < 64) begin @(negedge clk); cyc++; end
            if (!out_valid) begin
                chk("leaf_timeout", out_valid, 1'b1);
                n_rst = 1'b0; @(negedge clk); n_rst = 1'b1;
                return;
            end
            chk("leaf_latency", cyc, e.lat);
            chk("leaf_tri", out_tri, e.t);
            chk("leaf_level", out_level, e.lvl);
            chk("leaf_last", out_last, e.last);
            if (idx == 0) first = out_tri;
            if (kill_at == idx + 1) begin
                if (kill_rst) n_rst = 1'b0; else abort = 1'b1;
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                n_rst = 1'b1; abort = 1'b0; out_ready = 1'b0;
                chk("kill_valid", out_valid, 1'b0);
                chk("kill_busy", busy, 1'b0);
                chk("kill_in_ready", in_ready, 1'b1);
                chk("kill_last", out_last, 1'b0);
                if (kill_rst) begin
                    chk("rst_tri", out_tri, '0);
                    chk("rst_level", out_level, '0);
                end
                return;
            end
            stall_n = rand_stall ? int'($urandom_range(0, 2)) : 0;
            if (long_stall && idx == 3) stall_n = 5;
            repeat (stall_n) begin
                @(negedge clk);
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_tri", out_tri, e.t);
                chk("stall_level", out_level, e.lvl);
                chk("stall_last", out_last, e.last);
            end
            out_ready = 1'b1;
            @(posedge clk);
            nleaves++;
            @(negedge clk);
            out_ready = 1'b0;
            idx++; cyc = 1;
        end
        chk("done_valid", out_valid, 1'b0);
        chk("done_busy", busy, 1'b0);
        chk("done_in_ready", in_ready, 1'b1);
    endtask

    logic [9*CW-1:0] fl, t1, tc, rt;
    logic [TW-1:0]   rthr;
    int              nl, mode;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_level", out_level, '0);
        chk("rst_out_tri", out_tri, '0);
        chk("rst_busy", busy, 1'b0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        // No split: one leaf, unchanged.
        t1 = tri9(0, 0, 0, 4, 0, 0, 0, 2, 0);
        run_tri(t1, 100, 0, 0, 0, 0, fl, nl);
        chk("c1_leaf", fl, t1);
        chk("c1_count", nl, 1);

        // One split on QR.
        run_tri(t1, 16, 0, 0, 0, 0, fl, nl);
        chk("c2_leaf", fl, tri9(4, 0, 0, 2, 1, 0, 0, 0, 0));
        chk("c2_count", nl, 2);

        // QR/RP tie goes to QR.
        run_tri(tri9(-2, 0, 0, 2, 0, 0, 0, 4, 0), 19, 0, 0, 0, 0, fl, nl);
        chk("tie_leaf", fl, tri9(2, 0, 0, 1, 2, 0, -2, 0, 0));

        // Midpoint rounds toward -inf.
        run_tri(tri9(-3, 0, -1, 0, 0, 0, 0, 1, 0), 9, 0, 0, 0, 0, fl, nl);
        chk("floor_leaf", fl, tri9(0, 1, 0, -2, 0, -1, 0, 0, 0));
        chk("floor_count", nl, 2);

        // Level cap with a 5-cycle stall mid-stream.
        tc = tri9(0, 0, 0, 4000, 0, 7, 0, 3000, -9);
        run_tri(tc, 0, 0, 1, 0, 0, fl, nl);
        chk("cap_count", nl, 16);

        // Abort during the 3rd leaf, then a clean run.
        run_tri(tc, 0, 0, 0, 3, 0, fl, nl);
        run_tri(t1, 16, 0, 0, 0, 0, fl, nl);
        chk("post_abort_count", nl, 2);

        // Abort beats a same-cycle input handshake.
        @(negedge clk);
        in_tri = t1; thresh_sq = 100; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_no_accept", busy, 1'b0);
        @(negedge clk);
        chk("abort_no_leaf", out_valid, 1'b0);

        // Reset during the 3rd leaf, then a clean run.
        run_tri(tc, 0, 0, 0, 3, 1, fl, nl);
        run_tri(t1, 100, 0, 0, 0, 0, fl, nl);
        chk("post_rst_count", nl, 1);

        // Randomized triangles with random stalls.
        for (int r = 0; r < 40; r++) begin
            mode = int'($urandom_range(0, 7));
            for (int k = 0; k < 9; k++)
                rt[(8-k)*CW +: CW] = (mode < 2) ? CW'($urandom)
                                                : CW'(int'($urandom_range(0, 127)) - 64);
            if (mode == 7) rt = {3{rt[9*CW-1 -: 3*CW]}};
            if (mode < 2) rthr = TW'({$urandom, $urandom}) >> $urandom_range(2, 30);
            else          rthr = TW'($urandom_range(0, 3000));
            run_tri(rt, rthr, 1, 0, 0, 0, fl, nl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
